ir_peak_detect: RTL and testbench
=================================

IR_PEAK_DETECT -- requirements
Module: ir_peak_detect

Interface
REQ-001 Parameter DATA_W, 20, width of filtered sample.
REQ-002 Parameter CNT_W, 12, width of interval counter.
REQ-003 Parameter HYST, 20'd2048, absolute hysteresis for peak/trough declaration.
REQ-004 Parameter MIN_INTERVAL, 150, refractory period in samples (0.3 s at 500 Hz, 200 bpm).
REQ-005 Parameter MAX_INTERVAL, 1000, timeout in samples (2 s at 500 Hz, 30 bpm).
REQ-006 CLK_Filter  in  1  filter clock; all state updates on its rising edge.
REQ-007 rst_n  in  1  reset; asynchronous, active-low.
REQ-008 in_valid  in  1  one-cycle strobe; in_data holds a new filtered IR sample.
REQ-009 in_data  in  DATA_W  unsigned filtered IR sample from the FIR stage.
REQ-010 beat_pulse  out  1  one-cycle pulse per accepted peak.
REQ-011 beat_interval  out  CNT_W  samples between the last two accepted peaks.
REQ-012 interval_valid  out  1  high once beat_interval holds a measured value.
REQ-013 peak_value  out  DATA_W  amplitude of the last accepted peak.
REQ-014 no_pulse  out  1  high after timeout; cleared by the next accepted peak.

Function
REQ-015 The block SHALL act only on cycles with in_valid=1; otherwise all state SHALL hold and beat_pulse SHALL be 0.
REQ-016 The FSM SHALL have states IDLE, RISING and FALLING.
REQ-017 IDLE: the first valid sample SHALL load run_max=run_min=in_data and move the FSM to RISING.
REQ-018 RISING: run_max SHALL track max(run_max, in_data); when run_max - in_data >= HYST (computed DATA_W+1 wide, unsigned), a peak candidate SHALL be declared.
REQ-019 On a peak candidate, the FSM SHALL move to FALLING with run_min=in_data, whether or not the peak is accepted.
REQ-020 FALLING: run_min SHALL track min(run_min, in_data); when in_data - run_min >= HYST, the FSM SHALL move to RISING with run_max=in_data.
REQ-021 The sample counter cnt SHALL increment on every valid sample, saturating at MAX_INTERVAL.
REQ-022 A candidate SHALL be accepted when no reference peak exists (have_ref=0) or cnt+1 >= MIN_INTERVAL; otherwise it SHALL be ignored: no pulse, cnt not cleared.
REQ-023 Accepted peak: beat_pulse=1 for exactly one cycle, peak_value=run_max, cnt cleared to 0, have_ref set, no_pulse cleared.
REQ-024 Accepted peak with have_ref=1 beforehand: beat_interval=cnt+1 and interval_valid=1; with have_ref=0, beat_interval and interval_valid SHALL be unchanged.
REQ-025 Latency: outputs SHALL update on the clock edge after the cycle in which the triggering in_valid sample is present (1 cycle).
REQ-026 Timeout: if cnt+1 reaches MAX_INTERVAL on a sample without an accepted peak, then no_pulse=1, have_ref=0, interval_valid=0, and the FSM SHALL move to IDLE.
REQ-027 Simultaneous accepted peak and timeout on the same sample: the peak SHALL win; beat_interval=MAX_INTERVAL and no timeout.
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 rst_n low SHALL immediately force: FSM=IDLE, cnt=0, have_ref=0, run_max=run_min=0, beat_pulse=0, beat_interval=0, interval_valid=0, peak_value=0, no_pulse=0.
REQ-030 Reset asserted mid-operation SHALL discard all history; the first sample after release SHALL be treated as in REQ-017.

Structure
REQ-031 The shared package ppg_pkg SHALL hold DATA_W, CNT_W, the FSM state encoding and the 500 Hz sample-rate constant.
REQ-032 The interval counter with saturation and timeout compare SHALL be a sub-module, ir_beat_interval_cnt; the FSM and extremum tracking SHALL remain in ir_peak_detect.

Verification
REQ-033 Reset: drive rst_n=0 mid-stream -> all outputs 0 within the same cycle, and the FSM in IDLE.
REQ-034 Triangle 0->40000->0, period 250 samples -> first beat: beat_pulse, interval_valid=0, peak_value=40000; second beat: beat_interval=250, interval_valid=1.
REQ-035 Extra 40000 peak 100 samples after an accepted beat, then the next at 250 -> no pulse at 100; next beat_interval=250.
REQ-036 Constant 30000 for 1000 samples after a beat -> no_pulse=1 at sample 1000, interval_valid=0, FSM in IDLE; the next valid triangle clears no_pulse.
REQ-037 Ripple of 1000 p-p around 30000 -> no beat_pulse ever.
REQ-038 Accepted peak on exactly sample 1000 -> beat_pulse=1, beat_interval=1000, no_pulse=0.

Source files
------------

// File: rtl/ppg_pkg.sv
// Shared constants and FSM state encoding for the PPG IR processing chain.
package ppg_pkg;

  localparam int unsigned DATA_W         = 20;
  localparam int unsigned CNT_W          = 12;
  localparam int unsigned SAMPLE_RATE_HZ = 500;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RISING  = 2'd1,
    FALLING = 2'd2
  } peak_state_t;

endpackage

// File: rtl/ir_beat_interval_cnt.sv
// Sample counter since the last accepted peak: saturates at MAX_INTERVAL and
// flags the refractory and timeout thresholds against the incremented count.
module ir_beat_interval_cnt
  import ppg_pkg::*;
#(
  parameter int unsigned CNT_W        = ppg_pkg::CNT_W,
  parameter int unsigned MIN_INTERVAL = 150,
  parameter int unsigned MAX_INTERVAL = 1000
) (
  input  logic             CLK_Filter,
  input  logic             rst_n,
  input  logic             step,
  input  logic             clear,
  output logic [CNT_W-1:0] interval,
  output logic             min_met,
  output logic             timeout
);

  localparam logic [CNT_W:0] MIN_C = (CNT_W+1)'(MIN_INTERVAL);
  localparam logic [CNT_W:0] MAX_C = (CNT_W+1)'(MAX_INTERVAL);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0]   cnt_inc;

  assign cnt_inc  = {1'b0, cnt} + 1'b1;
  assign interval = cnt_inc[CNT_W-1:0];
  assign min_met  = (cnt_inc >= MIN_C);
  // Equality only: once saturated the timeout must not re-fire every sample.
  assign timeout  = (cnt_inc == MAX_C);

  always_ff @(posedge CLK_Filter or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (step) begin
      if (clear)
        cnt <= '0;
      else if (cnt_inc >= MAX_C)
        cnt <= MAX_C[CNT_W-1:0];
      else
        cnt <= cnt_inc[CNT_W-1:0];
    end
  end

endmodule

// File: rtl/ir_peak_detect.sv
// Hysteresis peak detector on filtered IR samples: tracks running extrema,
// gates peaks by a refractory period and flags loss of pulse on timeout.
module ir_peak_detect
  import ppg_pkg::*;
#(
  parameter int unsigned        DATA_W       = ppg_pkg::DATA_W,
  parameter int unsigned        CNT_W        = ppg_pkg::CNT_W,
  parameter logic [DATA_W-1:0]  HYST         = DATA_W'(2048),
  parameter int unsigned        MIN_INTERVAL = 150,
  parameter int unsigned        MAX_INTERVAL = 1000
) (
  input  logic              CLK_Filter,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              beat_pulse,
  output logic [CNT_W-1:0]  beat_interval,
  output logic              interval_valid,
  output logic [DATA_W-1:0] peak_value,
  output logic              no_pulse
);

  peak_state_t       state, state_next;
  logic [DATA_W-1:0] run_max, run_min, run_max_next, run_min_next;
  logic [DATA_W-1:0] max_upd, min_upd;
  logic [DATA_W:0]   rise_gap, fall_gap;
  logic              have_ref, cand, accept;
  logic [CNT_W-1:0]  cnt_interval;
  logic              min_met, timeout;

  ir_beat_interval_cnt #(
    .CNT_W        (CNT_W),
    .MIN_INTERVAL (MIN_INTERVAL),
    .MAX_INTERVAL (MAX_INTERVAL)
  ) u_cnt (
    .CLK_Filter (CLK_Filter),
    .rst_n      (rst_n),
    .step       (in_valid),
    .clear      (accept),
    .interval   (cnt_interval),
    .min_met    (min_met),
    .timeout    (timeout)
  );

  // Gaps are taken against the already-updated extremum so they never wrap.
  assign max_upd  = (in_data > run_max) ? in_data : run_max;
  assign min_upd  = (in_data < run_min) ? in_data : run_min;
  assign rise_gap = {1'b0, max_upd} - {1'b0, in_data};
  assign fall_gap = {1'b0, in_data} - {1'b0, min_upd};
  assign accept   = cand && (!have_ref || min_met);

  always_comb begin
    state_next   = state;
    run_max_next = run_max;
    run_min_next = run_min;
    cand         = 1'b0;
    if (in_valid) begin
      case (state)
        IDLE: begin
          run_max_next = in_data;
          run_min_next = in_data;
          state_next   = RISING;
        end
        RISING: begin
          run_max_next = max_upd;
          if (rise_gap >= {1'b0, HYST}) begin
            cand         = 1'b1;
            run_min_next = in_data;
            state_next   = FALLING;
          end
        end
        FALLING: begin
          run_min_next = min_upd;
          if (fall_gap >= {1'b0, HYST}) begin
            run_max_next = in_data;
            state_next   = RISING;
          end
        end
        default: state_next = IDLE;
      endcase
      if (timeout && !accept)
        state_next = IDLE;
    end
  end

  always_ff @(posedge CLK_Filter or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      run_max <= '0;
      run_min <= '0;
    end else begin
      state   <= state_next;
      run_max <= run_max_next;
      run_min <= run_min_next;
    end
  end

  always_ff @(posedge CLK_Filter or negedge rst_n) begin
    if (!rst_n) begin
      beat_pulse     <= 1'b0;
      beat_interval  <= '0;
      interval_valid <= 1'b0;
      peak_value     <= '0;
      no_pulse       <= 1'b0;
      have_ref       <= 1'b0;
    end else begin
      beat_pulse <= 1'b0;
      if (in_valid) begin
        if (accept) begin
          beat_pulse <= 1'b1;
          peak_value <= max_upd;
          have_ref   <= 1'b1;
          no_pulse   <= 1'b0;
          if (have_ref) begin
            beat_interval  <= cnt_interval;
            interval_valid <= 1'b1;
          end
        end else if (timeout) begin
          no_pulse       <= 1'b1;
          have_ref       <= 1'b0;
          interval_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ir_peak_detect.sv
// Scoreboard bench for ir_peak_detect: randomized waveforms feed an integer
// reference model; a monitor pops expected beat/timeout events as they appear.
module tb_ir_peak_detect;
  import ppg_pkg::*;

  localparam int HYST_I  = 2048;
  localparam int MIN_I   = 150;
  localparam int MAX_I   = 1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [19:0] in_data;
  logic        beat_pulse;
  logic [11:0] beat_interval;
  logic        interval_valid;
  logic [19:0] peak_value;
  logic        no_pulse;

  ir_peak_detect #(
    .DATA_W       (20),
    .CNT_W        (12),
    .HYST         (20'd2048),
    .MIN_INTERVAL (150),
    .MAX_INTERVAL (1000)
  ) dut (
    .CLK_Filter     (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .beat_pulse     (beat_pulse),
    .beat_interval  (beat_interval),
    .interval_valid (interval_valid),
    .peak_value     (peak_value),
    .no_pulse       (no_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_beat;
    int interval;
    bit ivalid;
    int peak;
    bit np;
  } ev_t;

  ev_t exp_q[$];
  int  total  = 0;
  int  passed = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference model in plain integers: mode 0 = waiting, 1 = climbing, 2 = descending.
  int m_mode, m_max, m_min, m_cnt, m_interval, m_peak;
  bit m_ref, m_ivalid, m_np;

  function automatic void model_reset();
    m_mode = 0; m_max = 0; m_min = 0; m_cnt = 0;
    m_interval = 0; m_peak = 0;
    m_ref = 0; m_ivalid = 0; m_np = 0;
  endfunction

  function automatic void model_sample(input int d);
    int  since = m_cnt + 1;
    bit  cand  = 0;
    int  top   = 0;
    ev_t e;
    if (m_mode == 0) begin
      m_max = d; m_min = d; m_mode = 1;
    end else if (m_mode == 1) begin
      if (d > m_max) m_max = d;
      if (m_max - d >= HYST_I) begin
        cand = 1; top = m_max; m_min = d; m_mode = 2;
      end
    end else begin
      if (d < m_min) m_min = d;
      if (d - m_min >= HYST_I) begin
        m_max = d; m_mode = 1;
      end
    end
    if (cand && (!m_ref || since >= MIN_I)) begin
      if (m_ref) begin
        m_interval = since;
        m_ivalid   = 1;
      end
      m_peak = top; m_cnt = 0; m_ref = 1; m_np = 0;
      e = '{is_beat: 1, interval: m_interval, ivalid: m_ivalid, peak: m_peak, np: 0};
      exp_q.push_back(e);
    end else begin
      m_cnt = (since > MAX_I) ? MAX_I : since;
      if (since == MAX_I) begin
        if (!m_np) begin
          e = '{is_beat: 0, interval: m_interval, ivalid: 0, peak: m_peak, np: 1};
          exp_q.push_back(e);
        end
        m_np = 1; m_ref = 0; m_ivalid = 0; m_mode = 0;
      end
    end
  endfunction

  task automatic idle_cycle();
    @(posedge clk); #2;
    in_valid = 1'b0;
  endtask

  task automatic send(input int d);
    while ($urandom_range(3) == 0) idle_cycle();
    @(posedge clk); #2;
    in_valid = 1'b1;
    in_data  = 20'(d);
    model_sample(d);
  endtask

  task automatic triangle(input int periods, input int spike_period);
    int v;
    for (int p = 0; p < periods; p++) begin
      for (int i = 0; i < 250; i++) begin
        v = (i <= 125) ? i * 320 : (250 - i) * 320;
        v = v + int'($urandom_range(60)) - 30;
        if (v < 0) v = 0;
        if (p == spike_period && i >= 225 && i < 230) v = 40000;
        send(v);
      end
    end
  endtask

  initial begin : monitor
    bit np_prev = 0;
    ev_t e;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        np_prev = 0;
      end else begin
        if (beat_pulse || (no_pulse && !np_prev)) begin
          if (exp_q.size() == 0) begin
            total++;
            $display("FAIL unexpected_event: beat_pulse=%0d no_pulse=%0d with no event expected",
                     beat_pulse, no_pulse);
          end else begin
            e = exp_q.pop_front();
            check("event_is_beat", beat_pulse, e.is_beat);
            check("beat_interval", beat_interval, e.interval);
            check("interval_valid", interval_valid, e.ivalid);
            check("peak_value", peak_value, e.peak);
            check("no_pulse", no_pulse, e.np);
            if (!e.is_beat) check("timeout_state", int'(dut.state), int'(IDLE));
          end
        end
        np_prev = no_pulse;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_beat_pulse"}, beat_pulse, 0);
    check({tag, "_beat_interval"}, beat_interval, 0);
    check({tag, "_interval_valid"}, interval_valid, 0);
    check({tag, "_peak_value"}, peak_value, 0);
    check({tag, "_no_pulse"}, no_pulse, 0);
    check({tag, "_state"}, int'(dut.state), int'(IDLE));
  endtask

  initial begin : stimulus
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    #1; rst_n = 1'b1;

    triangle(4, -1);
    triangle(3, 1);
    for (int i = 0; i < 1100; i++) send(30000);
    triangle(3, -1);

    // Exact-boundary peak: the second drop lands on sample 1000 after the first beat.
    for (int i = 0; i < 200; i++) send(0);
    send(40000);
    send(0);
    for (int s = 1; s <= 10; s++) send(0);
    for (int s = 11; s <= 999; s++) send(40000);
    send(0);
    triangle(1, -1);

    repeat (3) idle_cycle();
    check("pre_reset_peak_value", peak_value, m_peak);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid");
    model_reset();
    repeat (2) @(posedge clk);
    #2; rst_n = 1'b1;

    for (int i = 0; i < 1200; i++) send(29500 + int'($urandom_range(1000)));
    triangle(2, -1);

    repeat (4) idle_cycle();
    check("pending_events", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
